// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Pairs with regfile_wb_fifo and regfile_wb_arbiter.
package regfile_wb_arbiter_pkg;

    localparam int AW_DEF   = 5;
    localparam int DW_DEF   = 32;
    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] data;
        logic              kill;
    } lu_entry_t;

    typedef enum logic {
        ARB_NORMAL  = 1'b0,
        ARB_STARVED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Circular buffer for long-latency results with kill-by-address and
// live-entry address matching for decode hazard detection.
module regfile_wb_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int AW    = AW_DEF,
    parameter  int DW    = DW_DEF,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic          kill_en,
    input  logic [AW-1:0] kill_addr,
    input  logic [AW-1:0] rd_addr1,
    input  logic [AW-1:0] rd_addr2,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data,
    output logic          head_kill,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          match1,
    output logic          match2
);

    logic [AW-1:0]    addr_mem [DEPTH];
    logic [DW-1:0]    data_mem [DEPTH];
    logic [DEPTH-1:0] kill_mem;
    logic [DEPTH-1:0] valid_mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];
    assign head_kill = kill_mem[rd_ptr];

    // Kills only touch occupied slots, so a push into the write slot never collides with them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            kill_mem  <= '0;
            valid_mem <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && valid_mem[i] && (addr_mem[i] == kill_addr)) begin
                    kill_mem[i] <= 1'b1;
                end
            end
            if (do_pop) begin
                valid_mem[rd_ptr] <= 1'b0;
                rd_ptr            <= rd_ptr + PW'(1);
            end
            if (do_push) begin
                valid_mem[wr_ptr] <= 1'b1;
                kill_mem[wr_ptr]  <= kill_en && (push_addr == kill_addr);
                wr_ptr            <= wr_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    always_comb begin
        match1 = 1'b0;
        match2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_mem[i] && !kill_mem[i]) begin
                if (addr_mem[i] == rd_addr1) begin
                    match1 = 1'b1;
                end
                if (addr_mem[i] == rd_addr2) begin
                    match2 = 1'b1;
                end
            end
        end
        if (rd_addr1 == AW'(REG_ZERO)) begin
            match1 = 1'b0;
        end
        if (rd_addr2 == AW'(REG_ZERO)) begin
            match2 = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between pipeline write-back (priority)
// and a queued long-latency unit; raises stall_req when the queue head starves.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter  int DEPTH        = 4,
    parameter  int STARVE_LIMIT = 3,
    parameter  int AW           = AW_DEF,
    parameter  int DW           = DW_DEF,
    localparam int CW           = $clog2(DEPTH) + 1,
    localparam int SW           = $clog2(STARVE_LIMIT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic          lu_valid,
    output logic          lu_ready,
    input  logic [AW-1:0] lu_addr,
    input  logic [DW-1:0] lu_data,
    output logic          rf_we,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_data,
    input  logic [AW-1:0] rd_addr1,
    input  logic [AW-1:0] rd_addr2,
    output logic          hazard1,
    output logic          hazard2,
    output logic          stall_req,
    output logic [CW-1:0] fifo_count
);

    arb_state_t    state;
    arb_state_t    state_next;
    logic          stall_next;
    logic [SW-1:0] starve_cnt;

    logic          wb_win;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic          head_kill;
    logic          head_write;

    // A write-back to r0 is treated as an idle port so the queue can drain.
    assign wb_win     = wb_we && (wb_addr != AW'(REG_ZERO));
    assign lu_ready   = !fifo_full;
    assign fifo_push  = lu_valid && lu_ready;
    assign fifo_pop   = !wb_win && !fifo_empty;
    assign head_write = fifo_pop && !head_kill && (head_addr != AW'(REG_ZERO));

    regfile_wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_addr (lu_addr),
        .push_data (lu_data),
        .pop       (fifo_pop),
        .kill_en   (wb_win),
        .kill_addr (wb_addr),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .head_addr (head_addr),
        .head_data (head_data),
        .head_kill (head_kill),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .match1    (hazard1),
        .match2    (hazard2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we   <= 1'b0;
            rf_addr <= '0;
            rf_data <= '0;
        end else if (wb_win) begin
            rf_we   <= 1'b1;
            rf_addr <= wb_addr;
            rf_data <= wb_data;
        end else if (head_write) begin
            rf_we   <= 1'b1;
            rf_addr <= head_addr;
            rf_data <= head_data;
        end else begin
            rf_we   <= 1'b0;
        end
    end

    // Counts cycles the queue head loses the port; any pop restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (fifo_pop) begin
            starve_cnt <= '0;
        end else if (!fifo_empty && wb_win && (starve_cnt != SW'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB_NORMAL;
            stall_req <= 1'b0;
        end else begin
            state     <= state_next;
            stall_req <= stall_next;
        end
    end

    // A zero count while STARVED means the head was popped on the previous edge.
    always_comb begin
        state_next = state;
        case (state)
            ARB_NORMAL: begin
                if (starve_cnt == SW'(STARVE_LIMIT)) begin
                    state_next = ARB_STARVED;
                end
            end
            ARB_STARVED: begin
                if (starve_cnt == '0) begin
                    state_next = ARB_NORMAL;
                end
            end
            default: state_next = ARB_NORMAL;
        endcase
    end

    always_comb begin
        stall_next = (state_next == ARB_STARVED);
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vectors and sequences
// plus randomized traffic against a queue-based reference model.
module tb_regfile_wb_arbiter;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 3;
    localparam int AW           = 5;
    localparam int DW           = 32;
    localparam int CW           = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          lu_valid;
    logic          lu_ready;
    logic [AW-1:0] lu_addr;
    logic [DW-1:0] lu_data;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic [AW-1:0] rd_addr1;
    logic [AW-1:0] rd_addr2;
    logic          hazard1;
    logic          hazard2;
    logic          stall_req;
    logic [CW-1:0] fifo_count;

    regfile_wb_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT),
        .AW           (AW),
        .DW           (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .lu_valid   (lu_valid),
        .lu_ready   (lu_ready),
        .lu_addr    (lu_addr),
        .lu_data    (lu_data),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .hazard1    (hazard1),
        .hazard2    (hazard2),
        .stall_req  (stall_req),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: an ordered list of pending results plus a few scalars.
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            kill;
    } ref_entry_t;

    ref_entry_t    ref_q[$];
    bit            ref_we;
    logic [AW-1:0] ref_addr;
    logic [DW-1:0] ref_data;
    bit            ref_stall;
    bit            ref_popped;
    int            ref_streak;
    logic [DW-1:0] shadow_rf [32];

    typedef struct {
        logic          wb_we;
        logic [AW-1:0] wb_addr;
        logic [DW-1:0] wb_data;
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
    } wb_vec_t;

    wb_vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic w_we, input logic [AW-1:0] w_addr, input logic [DW-1:0] w_data,
                                 input logic l_valid, input logic [AW-1:0] l_addr, input logic [DW-1:0] l_data,
                                 input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        wb_we    = w_we;
        wb_addr  = w_addr;
        wb_data  = w_data;
        lu_valid = l_valid;
        lu_addr  = l_addr;
        lu_data  = l_data;
        rd_addr1 = r1;
        rd_addr2 = r2;
    endtask

    function automatic bit ref_hazard(input logic [AW-1:0] rd);
        if (rd == '0) return 1'b0;
        foreach (ref_q[i]) begin
            if (!ref_q[i].kill && ref_q[i].addr == rd) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic ref_reset();
        ref_q.delete();
        ref_we     = 1'b0;
        ref_addr   = '0;
        ref_data   = '0;
        ref_stall  = 1'b0;
        ref_popped = 1'b0;
        ref_streak = 0;
    endtask

    // Advance the model across one clock edge using the inputs currently driven.
    task automatic ref_edge();
        bit         wb_win;
        bit         ready;
        bit         busy;
        bit         popped;
        bit         next_stall;
        ref_entry_t head;
        wb_win     = wb_we && (wb_addr != '0);
        ready      = (ref_q.size() < DEPTH);
        busy       = (ref_q.size() > 0);
        popped     = 1'b0;
        next_stall = ref_stall ? !ref_popped : (ref_streak == STARVE_LIMIT);
        ref_we     = 1'b0;
        if (wb_win) begin
            foreach (ref_q[i]) begin
                if (ref_q[i].addr == wb_addr) ref_q[i].kill = 1'b1;
            end
            ref_we   = 1'b1;
            ref_addr = wb_addr;
            ref_data = wb_data;
        end else if (busy) begin
            head   = ref_q.pop_front();
            popped = 1'b1;
            if (!head.kill && head.addr != '0) begin
                ref_we   = 1'b1;
                ref_addr = head.addr;
                ref_data = head.data;
            end
        end
        if (lu_valid && ready) begin
            ref_q.push_back('{addr: lu_addr, data: lu_data, kill: (wb_win && lu_addr == wb_addr)});
        end
        if (popped) ref_streak = 0;
        else if (busy && wb_win && ref_streak < STARVE_LIMIT) ref_streak++;
        ref_stall  = next_stall;
        ref_popped = popped;
    endtask

    task automatic step();
        #1;
        checkOutput("lu_ready", 32'(lu_ready), 32'(ref_q.size() < DEPTH));
        checkOutput("fifo_count", 32'(fifo_count), 32'(ref_q.size()));
        checkOutput("hazard1", 32'(hazard1), 32'(ref_hazard(rd_addr1)));
        checkOutput("hazard2", 32'(hazard2), 32'(ref_hazard(rd_addr2)));
        ref_edge();
        @(posedge clk);
        #1;
        checkOutput("rf_we", 32'(rf_we), 32'(ref_we));
        if (ref_we) begin
            checkOutput("rf_addr", 32'(rf_addr), 32'(ref_addr));
            checkOutput("rf_data", rf_data, ref_data);
        end
        checkOutput("stall_req", 32'(stall_req), 32'(ref_stall));
        if (rf_we) shadow_rf[rf_addr] = rf_data;
    endtask

    task automatic idle(input logic [AW-1:0] r1);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, r1, '0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd8,  32'h55,       1'b1, 5'd8,  32'h55};
        vecs[1] = '{1'b0, 5'd8,  32'h66,       1'b0, 5'd0,  32'h0};
        vecs[2] = '{1'b1, 5'd0,  32'h99,       1'b0, 5'd0,  32'h0};
        vecs[3] = '{1'b1, 5'd31, 32'hdeadbeef, 1'b1, 5'd31, 32'hdeadbeef};
        vecs[4] = '{1'b1, 5'd1,  32'h1234,     1'b1, 5'd1,  32'h1234};
        vecs[5] = '{1'b0, 5'd5,  32'h77,       1'b0, 5'd0,  32'h0};
        foreach (shadow_rf[i]) shadow_rf[i] = '0;

        rst = 1'b1;
        idle('0);
        ref_reset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_rf_we", 32'(rf_we), 32'd0);
        checkOutput("reset_rf_addr", 32'(rf_addr), 32'd0);
        checkOutput("reset_rf_data", rf_data, 32'd0);
        checkOutput("reset_stall", 32'(stall_req), 32'd0);
        checkOutput("reset_count", 32'(fifo_count), 32'd0);
        checkOutput("reset_lu_ready", 32'(lu_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Write-back vectors: latency one, r0 never written.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].wb_we, vecs[i].wb_addr, vecs[i].wb_data, 1'b0, '0, '0, '0, '0);
            step();
            checkOutput("vec_rf_we", 32'(rf_we), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                checkOutput("vec_rf_addr", 32'(rf_addr), 32'(vecs[i].exp_addr));
                checkOutput("vec_rf_data", rf_data, vecs[i].exp_data);
            end
        end

        // Reset with two queued entries discards them.
        applyStimulus(1'b1, 5'd8, 32'h1, 1'b1, 5'd20, 32'h20, '0, '0);
        step();
        applyStimulus(1'b1, 5'd8, 32'h2, 1'b1, 5'd21, 32'h21, '0, '0);
        step();
        checkOutput("t1_count_before", 32'(fifo_count), 32'd2);
        idle('0);
        #2;
        rst = 1'b1;
        ref_reset();
        #1;
        checkOutput("t1_rf_we", 32'(rf_we), 32'd0);
        checkOutput("t1_count", 32'(fifo_count), 32'd0);
        checkOutput("t1_lu_ready", 32'(lu_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            idle('0);
            step();
            checkOutput("t1_no_write", 32'(rf_we), 32'd0);
        end

        // Long-latency result reaches the port two edges after the handshake.
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, 32'd7, '0, '0);
        step();
        checkOutput("t3_no_bypass", 32'(rf_we), 32'd0);
        idle(5'd9);
        #1;
        checkOutput("t3_hazard1", 32'(hazard1), 32'd1);
        step();
        checkOutput("t3_rf_we", 32'(rf_we), 32'd1);
        checkOutput("t3_rf_addr", 32'(rf_addr), 32'd9);
        checkOutput("t3_rf_data", rf_data, 32'd7);

        // Starvation: head blocked by write-back for three cycles.
        applyStimulus(1'b1, 5'd8, 32'h100, 1'b1, 5'd5, 32'h5, '0, '0);
        step();
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, 5'd8, 32'h100 + 32'(k), 1'b0, '0, '0, '0, '0);
            step();
            checkOutput("t4_stall_rise", 32'(stall_req), 32'(k >= 4));
        end
        idle('0);
        step();
        checkOutput("t4_pop_we", 32'(rf_we), 32'd1);
        checkOutput("t4_pop_addr", 32'(rf_addr), 32'd5);
        checkOutput("t4_stall_hold", 32'(stall_req), 32'd1);
        idle('0);
        step();
        checkOutput("t4_stall_drop", 32'(stall_req), 32'd0);

        // Kill: younger write-back overtakes a queued result.
        applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd10, 32'h11, '0, '0);
        step();
        applyStimulus(1'b1, 5'd10, 32'hAA, 1'b0, '0, '0, 5'd10, '0);
        #1;
        checkOutput("t5_hazard_before", 32'(hazard1), 32'd1);
        step();
        checkOutput("t5_wb_addr", 32'(rf_addr), 32'd10);
        idle(5'd10);
        #1;
        checkOutput("t5_hazard_after", 32'(hazard1), 32'd0);
        step();
        checkOutput("t5_killed_no_we", 32'(rf_we), 32'd0);
        checkOutput("t5_count", 32'(fifo_count), 32'd0);
        checkOutput("t5_reg10", shadow_rf[10], 32'hAA);

        // Full queue: fifth result refused, then drain in push order.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 5'd8, 32'h8, 1'b1, AW'(11 + i), 32'h1000 + 32'(i), '0, '0);
            step();
        end
        checkOutput("t6_count_full", 32'(fifo_count), 32'd4);
        checkOutput("t6_lu_ready", 32'(lu_ready), 32'd0);
        applyStimulus(1'b1, 5'd8, 32'h8, 1'b1, 5'd15, 32'hF, '0, '0);
        step();
        checkOutput("t6_fifth_refused", 32'(fifo_count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            idle('0);
            step();
            checkOutput("t6_drain_we", 32'(rf_we), 32'd1);
            checkOutput("t6_drain_addr", 32'(rf_addr), 32'(11 + i));
            checkOutput("t6_drain_data", rf_data, 32'h1000 + 32'(i));
        end
        idle('0);
        step();
        checkOutput("t6_empty_we", 32'(rf_we), 32'd0);

        // Randomized traffic with alternating write-back pressure.
        for (int c = 0; c < 600; c++) begin
            int wb_pct;
            wb_pct = ((c / 50) % 2 == 1) ? 80 : 30;
            applyStimulus(1'($urandom_range(0, 99) < wb_pct), AW'($urandom_range(0, 7)), $urandom,
                          1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
                          AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
